// File: rtl/mux_arb_nto1_pkg.sv
// Shared definitions for the arbitrating N-to-1 mux: policy codes and sizing helpers.
package mux_arb_nto1_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Select width for n channels; never below one bit so ports stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_arb_pick.sv
// Combinational picker: first requesting channel scanning upward from start, with wrap.
module mux_arb_nto1_arb_pick
  import mux_arb_nto1_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    start,
  output logic                found,
  output logic [SEL_W-1:0]    winner
);

  localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W:0]   sum_w [CHANNELS];
  logic [SEL_W-1:0] cand  [CHANNELS];
  logic [CHANNELS-1:0] hit;

  // cand[k] is the channel visited k steps after start; start is always < CHANNELS.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
      assign sum_w[gi] = {1'b0, start} + (SEL_W + 1)'(gi);
      assign cand[gi]  = (sum_w[gi] >= CH_L) ? SEL_W'(sum_w[gi] - CH_L) : SEL_W'(sum_w[gi]);
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  assign found = |hit;

  always_comb begin
    winner = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrating mux with a one-entry registered output under valid/ready.
module mux_arb_nto1
  import mux_arb_nto1_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4,
  parameter int MODE     = ARB_RR,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  logic                out_valid_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_sel_reg;
  logic [SEL_W-1:0]    ptr_reg;
  logic [SEL_W-1:0]    ptr_next;
  logic                load_en;
  logic                found;
  logic                transfer;
  logic [SEL_W-1:0]    winner;
  logic [WIDTH-1:0]    chan_data [CHANNELS];

  mux_arb_nto1_arb_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req    (in_valid),
    .start  (ptr_reg),
    .found  (found),
    .winner (winner)
  );

  assign load_en  = !out_valid_reg || out_ready;
  // Gated by reset so no producer sees an accept while the block is held in reset.
  assign transfer = load_en && found && !reset;
  assign ptr_next = (winner == CH_LAST) ? '0 : winner + 1'b1;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = transfer && (winner == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (load_en) begin
      if (found) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[winner];
        out_sel_reg   <= winner;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Fixed priority scans from channel 0, so the pointer is simply tied off.
  generate
    if (MODE == ARB_RR) begin : g_rr
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ptr_reg <= '0;
        end else if (load_en && found) begin
          ptr_reg <= ptr_next;
        end
      end
    end else begin : g_fixed
      assign ptr_reg = '0;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench with per-instance scoreboards for the arbitrating N-to-1 mux.
module tb_mux_arb_nto1;
  import mux_arb_nto1_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // A: 4 ch round-robin, B: 5 ch round-robin, C: 4 ch fixed priority
  logic [3:0]  in_valid_a, in_ready_a;
  logic [23:0] in_data_a;
  logic        out_valid_a, out_ready_a;
  logic [5:0]  out_data_a;
  logic [1:0]  out_sel_a;

  logic [4:0]  in_valid_b, in_ready_b;
  logic [29:0] in_data_b;
  logic        out_valid_b, out_ready_b;
  logic [5:0]  out_data_b;
  logic [2:0]  out_sel_b;

  logic [3:0]  in_valid_c, in_ready_c;
  logic [23:0] in_data_c;
  logic        out_valid_c, out_ready_c;
  logic [5:0]  out_data_c;
  logic [1:0]  out_sel_c;

  mux_arb_nto1 #(.WIDTH(6), .CHANNELS(4), .MODE(ARB_RR)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_ready(out_ready_a));

  mux_arb_nto1 #(.WIDTH(6), .CHANNELS(5), .MODE(ARB_RR)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_ready(out_ready_b));

  mux_arb_nto1 #(.WIDTH(6), .CHANNELS(4), .MODE(ARB_FIXED)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_data(in_data_c),
    .in_ready(in_ready_c), .out_valid(out_valid_c), .out_data(out_data_c),
    .out_sel(out_sel_c), .out_ready(out_ready_c));

  int checks = 0;
  int fails  = 0;
  int qa[$];
  int qb[$];
  int qc[$];
  int ea, eb, ec;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words are encoded as sel*64 + data.
  always @(negedge clk) begin
    if (!reset && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_unexpected: got sel=%0d data=0x%02h, expected no word", out_sel_a, out_data_a);
      end else begin
        ea = qa.pop_front();
        $display("a word: sel=%0d data=0x%02h (expected sel=%0d data=0x%02h)", out_sel_a, out_data_a, ea / 64, ea % 64);
        chk("a_word", int'(out_sel_a) * 64 + int'(out_data_a), ea);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_unexpected: got sel=%0d data=0x%02h, expected no word", out_sel_b, out_data_b);
      end else begin
        eb = qb.pop_front();
        $display("b word: sel=%0d data=0x%02h (expected sel=%0d data=0x%02h)", out_sel_b, out_data_b, eb / 64, eb % 64);
        chk("b_word", int'(out_sel_b) * 64 + int'(out_data_b), eb);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_c && out_ready_c) begin
      if (qc.size() == 0) begin
        checks++; fails++;
        $display("FAIL c_unexpected: got sel=%0d data=0x%02h, expected no word", out_sel_c, out_data_c);
      end else begin
        ec = qc.pop_front();
        $display("c word: sel=%0d data=0x%02h (expected sel=%0d data=0x%02h)", out_sel_c, out_data_c, ec / 64, ec % 64);
        chk("c_word", int'(out_sel_c) * 64 + int'(out_data_c), ec);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", qa.size() + qb.size() + qc.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid_a = 4'b1111; in_data_a = {6'h13, 6'h12, 6'h11, 6'h10}; out_ready_a = 1'b1;
    in_valid_b = '0; in_data_b = '0; out_ready_b = 1'b1;
    in_valid_c = '0; in_data_c = '0; out_ready_c = 1'b1;

    // Reset state, with requests pending
    #12;
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_data", int'(out_data_a), 0);
    chk("rst_out_sel", int'(out_sel_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin with all channels valid
    for (int i = 0; i < 6; i++) qa.push_back((i % 4) * 64 + 16 + (i % 4));
    repeat (6) cyc();
    in_valid_a = '0;
    wait_empty();

    // Back-pressure: ptr is 2, ch2 word held while ch0 waits
    out_ready_a = 1'b0;
    in_valid_a = 4'b0100;
    in_data_a = {6'h00, 6'h2A, 6'h00, 6'h05};
    qa.push_back(2 * 64 + 6'h2A);
    qa.push_back(0 * 64 + 6'h05);
    cyc();
    in_valid_a = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(out_valid_a), 1);
      chk("stall_data", int'(out_data_a), 6'h2A);
      chk("stall_sel", int'(out_sel_a), 2);
      #1;
      chk("stall_in_ready", int'(in_ready_a), 0);
      cyc();
    end
    out_ready_a = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready_a), 4'b0001);
    cyc();
    in_valid_a = '0;
    wait_empty();

    // Reset mid-stream with a word held (ptr is 1, so ch3 wins)
    out_ready_a = 1'b0;
    in_valid_a = 4'b1000;
    in_data_a = {6'h33, 6'h00, 6'h21, 6'h00};
    cyc();
    chk("pre_rst_valid", int'(out_valid_a), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid_a), 0);
    chk("async_rst_data", int'(out_data_a), 0);
    chk("async_rst_sel", int'(out_sel_a), 0);
    chk("async_rst_in_ready", int'(in_ready_a), 0);
    in_valid_a = 4'b1010;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.push_back(1 * 64 + 6'h21);
    cyc();
    in_valid_a = '0;
    wait_empty();

    // 5-channel wrap: ch1 first sets ptr=2, then ch4/ch1 alternate
    in_data_b = {6'h04, 6'h00, 6'h00, 6'h01, 6'h00};
    in_valid_b = 5'b00010;
    qb.push_back(1 * 64 + 1);
    qb.push_back(4 * 64 + 4);
    qb.push_back(1 * 64 + 1);
    qb.push_back(4 * 64 + 4);
    #1;
    chk("b_first_in_ready", int'(in_ready_b), 5'b00010);
    cyc();
    in_valid_b = 5'b10010;
    #1;
    chk("b_wrap_in_ready", int'(in_ready_b), 5'b10000);
    repeat (3) cyc();
    in_valid_b = '0;
    wait_empty();

    // Fixed priority: ch0 beats ch3, then ch3 once ch0 drops
    in_data_c = {6'h3C, 6'h00, 6'h00, 6'h0A};
    in_valid_c = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      qc.push_back(0 * 64 + 6'h0A);
      #1;
      chk("c_prio_in_ready", int'(in_ready_c), 4'b0001);
      cyc();
    end
    in_valid_c = 4'b1000;
    qc.push_back(3 * 64 + 6'h3C);
    #1;
    chk("c_low_in_ready", int'(in_ready_c), 4'b1000);
    cyc();
    in_valid_c = '0;
    wait_empty();

    // Idle drain
    in_data_a = {6'h00, 6'h17, 6'h00, 6'h00};
    in_valid_a = 4'b0100;
    qa.push_back(2 * 64 + 6'h17);
    cyc();
    in_valid_a = '0;
    chk("drain_valid_hi", int'(out_valid_a), 1);
    cyc();
    chk("drain_valid_lo", int'(out_valid_a), 0);
    chk("drain_data_kept", int'(out_data_a), 6'h17);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
